// File: rtl/adc_async_fill_seq.sv
// adc_async_fill_seq: asynchronous-mode fill sequencer for one ADC channel.
// Drives the data-mux selects and checksum controls, plus the FIFO strobe and address.
//
// Ports:
//   clk, rst                    clock and synchronous active-high reset
//   fill_start, fill_stop       fill window control pulses
//   trigger                     async trigger pulse
//   adc_burst_valid             one data burst present at the mux this cycle
//   async_num_bursts            data bursts per waveform, latched at fill_start
//   fifo_almost_full, fifo_full DDR3 write FIFO status
//   select_*                    one-hot mux selects (combinational)
//   checksum_init/update        mux checksum controls (combinational)
//   fill_num .. num_fill_bursts registered header fields
//   wr_en, wr_adr               FIFO strobe/address aligned to the mux register
//   busy, fill_done             status
//   trig_dropped, overflow      sticky, cleared at fill_start
//
// Optional feature: ASYNC_WF_LIMIT_EN caps triggers per fill at MAX_WAVEFORMS.

module adc_async_fill_seq #(
    parameter logic [22:0] MAX_WAVEFORMS = 23'd4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fill_start,
    input  logic        fill_stop,
    input  logic        trigger,
    input  logic        adc_burst_valid,
    input  logic [13:0] async_num_bursts,
    input  logic        fifo_almost_full,
    input  logic        fifo_full,
    output logic        select_fill_hdr,
    output logic        select_waveform_hdr,
    output logic        select_dat,
    output logic        select_checksum,
    output logic        checksum_init,
    output logic        checksum_update,
    output logic [23:0] fill_num,
    output logic [22:0] current_waveform_num,
    output logic [22:0] waveform_start_adr,
    output logic [22:0] num_fill_bursts,
    output logic        wr_en,
    output logic [22:0] wr_adr,
    output logic        busy,
    output logic        fill_done,
    output logic        trig_dropped,
    output logic        overflow
);

    typedef enum logic [2:0] {
        IDLE, ARMED, WF_HDR, WF_DATA, FILL_HDR, CHECKSUM, DONE
    } state_t;

    state_t state, state_d;

    logic [13:0] nb_lat;
    logic [13:0] cnt;
    logic [22:0] ptr;
    logic [22:0] adr_d;
    logic        stop_pend;
    logic        ptr_inc;
    logic        take;
    logic        wf_end;
    logic        load_cnt;
    logic        set_drop;
    logic        set_pend;
    logic        to_fill_hdr;
    logic        wf_cap;

`ifdef ASYNC_WF_LIMIT_EN
    assign wf_cap = current_waveform_num >= MAX_WAVEFORMS;
`else
    logic unused_max;
    assign unused_max = ^MAX_WAVEFORMS;
    assign wf_cap = 1'b0;
`endif

    assign busy      = state != IDLE;
    assign fill_done = state == DONE;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d             = state;
        select_fill_hdr     = 1'b0;
        select_waveform_hdr = 1'b0;
        select_dat          = 1'b0;
        select_checksum     = 1'b0;
        checksum_init       = 1'b0;
        checksum_update     = 1'b0;
        ptr_inc             = 1'b0;
        take                = 1'b0;
        wf_end              = 1'b0;
        load_cnt            = 1'b0;
        set_drop            = 1'b0;
        set_pend            = 1'b0;
        to_fill_hdr         = 1'b0;
        unique case (state)
            IDLE: begin
                if (fill_start && !rst) begin
                    checksum_init = 1'b1;
                    state_d       = ARMED;
                end
            end
            ARMED: begin
                // A stop beats a same-cycle trigger, which is then not a drop.
                if (fill_stop || stop_pend) begin
                    to_fill_hdr = 1'b1;
                    state_d     = FILL_HDR;
                end else if (trigger) begin
                    if (fifo_almost_full || wf_cap) begin
                        set_drop = 1'b1;
                    end else begin
                        take    = 1'b1;
                        state_d = WF_HDR;
                    end
                end
            end
            WF_HDR: begin
                select_waveform_hdr = 1'b1;
                ptr_inc             = 1'b1;
                set_drop            = trigger;
                set_pend            = fill_stop;
                if (nb_lat == 14'd0) begin
                    wf_end  = 1'b1;
                    state_d = ARMED;
                end else begin
                    load_cnt = 1'b1;
                    state_d  = WF_DATA;
                end
            end
            WF_DATA: begin
                set_drop = trigger;
                set_pend = fill_stop;
                if (adc_burst_valid) begin
                    select_dat      = 1'b1;
                    checksum_update = 1'b1;
                    ptr_inc         = 1'b1;
                    if (cnt == 14'd1) begin
                        wf_end  = 1'b1;
                        state_d = ARMED;
                    end
                end
            end
            FILL_HDR: begin
                if (!fifo_almost_full) begin
                    select_fill_hdr = 1'b1;
                    state_d         = CHECKSUM;
                end
            end
            CHECKSUM: begin
                if (!fifo_almost_full) begin
                    select_checksum = 1'b1;
                    state_d         = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Address of the word the mux registers this cycle.
    always_comb begin
        adr_d = ptr;
        unique case (1'b1)
            select_fill_hdr: adr_d = 23'd0;
            select_checksum: adr_d = num_fill_bursts - 23'd1;
            default:         adr_d = ptr;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            nb_lat               <= '0;
            cnt                  <= '0;
            ptr                  <= '0;
            stop_pend            <= 1'b0;
            fill_num             <= '0;
            current_waveform_num <= '0;
            waveform_start_adr   <= '0;
            num_fill_bursts      <= '0;
            trig_dropped         <= 1'b0;
            overflow             <= 1'b0;
            wr_en                <= 1'b0;
            wr_adr               <= '0;
        end else begin
            if (checksum_init) begin
                fill_num             <= fill_num + 24'd1;
                nb_lat               <= async_num_bursts;
                cnt                  <= '0;
                ptr                  <= 23'd1;
                stop_pend            <= 1'b0;
                current_waveform_num <= '0;
                waveform_start_adr   <= '0;
                num_fill_bursts      <= '0;
                trig_dropped         <= 1'b0;
                overflow             <= 1'b0;
            end
            if (ptr_inc)  ptr <= ptr + 23'd1;
            if (take)     waveform_start_adr <= ptr;
            if (load_cnt) cnt <= nb_lat;
            if (select_dat) cnt <= cnt - 14'd1;
            if (wf_end)   current_waveform_num <= current_waveform_num + 23'd1;
            // Computed on entry so the field is stable while its select is high.
            if (to_fill_hdr) num_fill_bursts <= ptr + 23'd1;
            if (set_pend) stop_pend <= 1'b1;
            if (set_drop) trig_dropped <= 1'b1;
            if (wr_en && fifo_full) overflow <= 1'b1;
            wr_en  <= select_fill_hdr | select_waveform_hdr
                    | select_dat | select_checksum;
            wr_adr <= adr_d;
        end
    end

endmodule

// File: tb/tb_adc_async_fill_seq.sv
// tb_adc_async_fill_seq: directed self-checking bench for adc_async_fill_seq.
// Expected write addresses are queued at stimulus time and popped on wr_en.

module tb_adc_async_fill_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        fill_start;
    logic        fill_stop;
    logic        trigger;
    logic        adc_burst_valid;
    logic [13:0] async_num_bursts;
    logic        fifo_almost_full;
    logic        fifo_full;
    logic        select_fill_hdr;
    logic        select_waveform_hdr;
    logic        select_dat;
    logic        select_checksum;
    logic        checksum_init;
    logic        checksum_update;
    logic [23:0] fill_num;
    logic [22:0] current_waveform_num;
    logic [22:0] waveform_start_adr;
    logic [22:0] num_fill_bursts;
    logic        wr_en;
    logic [22:0] wr_adr;
    logic        busy;
    logic        fill_done;
    logic        trig_dropped;
    logic        overflow;

    int vectors = 0;
    int miscompares = 0;
    logic [22:0] exp_q[$];

`ifdef ASYNC_WF_LIMIT_EN
    localparam int NEXP = 2;
    localparam int LIM_DROP = 1;
`else
    localparam int NEXP = 3;
    localparam int LIM_DROP = 0;
`endif

    always #5 clk = ~clk;

    adc_async_fill_seq #(.MAX_WAVEFORMS(23'd2)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .fill_start          (fill_start),
        .fill_stop           (fill_stop),
        .trigger             (trigger),
        .adc_burst_valid     (adc_burst_valid),
        .async_num_bursts    (async_num_bursts),
        .fifo_almost_full    (fifo_almost_full),
        .fifo_full           (fifo_full),
        .select_fill_hdr     (select_fill_hdr),
        .select_waveform_hdr (select_waveform_hdr),
        .select_dat          (select_dat),
        .select_checksum     (select_checksum),
        .checksum_init       (checksum_init),
        .checksum_update     (checksum_update),
        .fill_num            (fill_num),
        .current_waveform_num(current_waveform_num),
        .waveform_start_adr  (waveform_start_adr),
        .num_fill_bursts     (num_fill_bursts),
        .wr_en               (wr_en),
        .wr_adr              (wr_adr),
        .busy                (busy),
        .fill_done           (fill_done),
        .trig_dropped        (trig_dropped),
        .overflow            (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk("sel_onehot", 32'($countones({select_fill_hdr,
            select_waveform_hdr, select_dat, select_checksum}) <= 1), 1);
        if (wr_en) begin
            if (exp_q.size() == 0) chk("unexpected_wr", 1, 0);
            else chk("wr_adr", 32'(wr_adr), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic start(input logic [13:0] nb, input logic [23:0] fn);
        async_num_bursts = nb;
        fill_start = 1'b1;
        #1;
        chk("checksum_init", 32'(checksum_init), 1);
        tick();
        fill_start = 1'b0;
        chk("fill_num", 32'(fill_num), 32'(fn));
        chk("busy_start", 32'(busy), 1);
        chk("drop_clear", 32'(trig_dropped), 0);
        chk("ovf_clear", 32'(overflow), 0);
        chk("cwn_clear", 32'(current_waveform_num), 0);
    endtask

    initial begin
        rst = 1'b1;
        fill_start = 1'b0;
        fill_stop = 1'b0;
        trigger = 1'b0;
        adc_burst_valid = 1'b0;
        async_num_bursts = '0;
        fifo_almost_full = 1'b0;
        fifo_full = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_fill_num", 32'(fill_num), 0);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_drop", 32'(trig_dropped), 0);

        // Fill 1: one waveform of three bursts.
        start(14'd3, 24'd1);
        trigger = 1'b1;
        exp_q.push_back(23'd1);
        tick();
        trigger = 1'b0;
        chk("t1_sel_wh", 32'(select_waveform_hdr), 1);
        chk("t1_wsa", 32'(waveform_start_adr), 1);
        chk("t1_cwn0", 32'(current_waveform_num), 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            adc_burst_valid = 1'b1;
            exp_q.push_back(23'(2 + i));
            #1;
            chk("t1_sel_dat", 32'(select_dat), 1);
            chk("t1_ck_upd", 32'(checksum_update), 1);
            tick();
        end
        adc_burst_valid = 1'b0;
        chk("t1_cwn1", 32'(current_waveform_num), 1);
        fill_stop = 1'b1;
        tick();
        fill_stop = 1'b0;
        chk("t1_sel_fh", 32'(select_fill_hdr), 1);
        chk("t1_nfb", 32'(num_fill_bursts), 6);
        exp_q.push_back(23'd0);
        exp_q.push_back(23'd5);
        tick();
        chk("t1_sel_ck", 32'(select_checksum), 1);
        tick();
        chk("t1_done", 32'(fill_done), 1);
        tick();
        chk("t1_done_pulse", 32'(fill_done), 0);
        chk("t1_idle", 32'(busy), 0);
        chk("t1_q_empty", 32'(exp_q.size()), 0);

        // Fill 2: trigger and stop during WF_DATA.
        start(14'd2, 24'd2);
        trigger = 1'b1;
        exp_q.push_back(23'd1);
        tick();
        trigger = 1'b0;
        tick();
        adc_burst_valid = 1'b1;
        trigger = 1'b1;
        exp_q.push_back(23'd2);
        tick();
        trigger = 1'b0;
        fill_stop = 1'b1;
        exp_q.push_back(23'd3);
        tick();
        adc_burst_valid = 1'b0;
        fill_stop = 1'b0;
        chk("t2_drop", 32'(trig_dropped), 1);
        chk("t2_cwn", 32'(current_waveform_num), 1);
        chk("t2_no_fh_yet", 32'(select_fill_hdr), 0);
        tick();
        chk("t2_sel_fh", 32'(select_fill_hdr), 1);
        chk("t2_nfb", 32'(num_fill_bursts), 5);
        exp_q.push_back(23'd0);
        exp_q.push_back(23'd4);
        tick();
        tick();
        chk("t2_done", 32'(fill_done), 1);
        tick();
        chk("t2_q_empty", 32'(exp_q.size()), 0);

        // Fill 3: header-only waveforms, stop+trigger together, stalled FILL_HDR.
        start(14'd0, 24'd3);
        trigger = 1'b1;
        exp_q.push_back(23'd1);
        tick();
        trigger = 1'b0;
        tick();
        trigger = 1'b1;
        exp_q.push_back(23'd2);
        tick();
        trigger = 1'b0;
        chk("t3_wsa", 32'(waveform_start_adr), 2);
        chk("t3_cwn1", 32'(current_waveform_num), 1);
        tick();
        chk("t3_cwn2", 32'(current_waveform_num), 2);
        fill_stop = 1'b1;
        trigger = 1'b1;
        fifo_almost_full = 1'b1;
        tick();
        fill_stop = 1'b0;
        trigger = 1'b0;
        chk("t3_no_wh", 32'(select_waveform_hdr), 0);
        for (int i = 0; i < 5; i++) begin
            chk("t3_fh_held", 32'(select_fill_hdr), 0);
            tick();
        end
        fifo_almost_full = 1'b0;
        #1;
        chk("t3_sel_fh", 32'(select_fill_hdr), 1);
        chk("t3_nfb", 32'(num_fill_bursts), 4);
        chk("t3_no_drop", 32'(trig_dropped), 0);
        chk("t3_ovf0", 32'(overflow), 0);
        exp_q.push_back(23'd0);
        exp_q.push_back(23'd3);
        fifo_full = 1'b1;
        tick();
        chk("t3_sel_ck", 32'(select_checksum), 1);
        tick();
        fifo_full = 1'b0;
        chk("t3_ovf", 32'(overflow), 1);
        chk("t3_done", 32'(fill_done), 1);
        tick();
        chk("t3_q_empty", 32'(exp_q.size()), 0);

        // Fill 4: reset in WF_DATA abandons the fill.
        start(14'd4, 24'd4);
        trigger = 1'b1;
        exp_q.push_back(23'd1);
        tick();
        trigger = 1'b0;
        tick();
        adc_burst_valid = 1'b1;
        exp_q.push_back(23'd2);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        adc_burst_valid = 1'b0;
        chk("r_busy", 32'(busy), 0);
        chk("r_wr_en", 32'(wr_en), 0);
        chk("r_fill_num", 32'(fill_num), 0);
        chk("r_cwn", 32'(current_waveform_num), 0);
        chk("r_wsa", 32'(waveform_start_adr), 0);
        chk("r_sel_dat", 32'(select_dat), 0);
        for (int i = 0; i < 3; i++) begin
            chk("r_no_done", 32'(fill_done), 0);
            tick();
        end
        chk("r_q_empty", 32'(exp_q.size()), 0);
        start(14'd1, 24'd1);
        trigger = 1'b1;
        fifo_almost_full = 1'b1;
        tick();
        trigger = 1'b0;
        fifo_almost_full = 1'b0;
        chk("af_drop", 32'(trig_dropped), 1);
        chk("af_no_wh", 32'(select_waveform_hdr), 0);
        fill_stop = 1'b1;
        tick();
        fill_stop = 1'b0;
        chk("af_nfb", 32'(num_fill_bursts), 2);
        exp_q.push_back(23'd0);
        exp_q.push_back(23'd1);
        tick();
        tick();
        chk("af_done", 32'(fill_done), 1);
        tick();

        // Fill 6: three triggers against a cap of two.
        start(14'd0, 24'd2);
        for (int i = 0; i < 3; i++) begin
            trigger = 1'b1;
            if (i < NEXP) exp_q.push_back(23'(i + 1));
            tick();
            trigger = 1'b0;
            tick();
        end
        chk("lim_cwn", 32'(current_waveform_num), 32'(NEXP));
        chk("lim_drop", 32'(trig_dropped), 32'(LIM_DROP));
        fill_stop = 1'b1;
        tick();
        fill_stop = 1'b0;
        chk("lim_nfb", 32'(num_fill_bursts), 32'(NEXP + 2));
        exp_q.push_back(23'd0);
        exp_q.push_back(23'(NEXP + 1));
        tick();
        tick();
        chk("lim_done", 32'(fill_done), 1);
        tick();
        chk("lim_q_empty", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/adc_async_fill_seq.md
# adc_async_fill_seq

Sequencer for one channel's asynchronous-mode fill. It drives the select, checksum and header-field inputs of the channel's ADC data mux so that every burst lands in the DDR3 write FIFO in order:
- waveform header plus data bursts for each accepted trigger;
- then the fill header;
- then the checksum.

It also generates the FIFO write strobe and the DDR3 burst address that are aligned to the mux's registered output.

## Interface
Parameters:
- MAX_WAVEFORMS, 23'd4096: per-fill trigger cap. Used only with ASYNC_WF_LIMIT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- fill_start  in  1  one-cycle pulse that begins a fill.
- fill_stop  in  1  one-cycle pulse that ends the trigger window.
- trigger  in  1  one-cycle async trigger pulse.
- adc_burst_valid  in  1  one 8-sample burst is present on the mux data inputs this cycle.
- async_num_bursts  in  14  data bursts per waveform. Sampled at fill_start.
- fifo_almost_full  in  1  DDR3 write FIFO almost full.
- fifo_full  in  1  DDR3 write FIFO full.
- select_fill_hdr, select_waveform_hdr, select_dat, select_checksum  out  1 each  mux selects. At most one is high in any cycle.
- checksum_init, checksum_update  out  1 each  mux checksum controls.
- fill_num  out  24  current fill number.
- current_waveform_num  out  23  waveform index / final waveform count.
- waveform_start_adr  out  23  burst address of the current waveform header.
- num_fill_bursts  out  23  total bursts in the fill.
- wr_en  out  1  FIFO write strobe.
- wr_adr  out  23  DDR3 burst address of the word written with wr_en.
- busy  out  1  high in every state except IDLE.
- fill_done  out  1  one-cycle pulse after the checksum is written.
- trig_dropped  out  1  sticky; cleared at fill_start.
- overflow  out  1  sticky; cleared at fill_start.

## Operation
States: IDLE, ARMED, WF_HDR, WF_DATA, FILL_HDR, CHECKSUM, DONE.

- **IDLE**
  - On fill_start: increment fill_num, latch async_num_bursts, clear all counters and sticky flags, pulse checksum_init for one cycle, set the write pointer ptr to 1, go to ARMED. Address 0 is reserved for the fill header.
  - fill_start in any other state is ignored.
- **ARMED**
  - fill_stop, or a pending stop: go to FILL_HDR.
  - Else trigger with fifo_almost_full low: waveform_start_adr <= ptr, go to WF_HDR.
  - Trigger with fifo_almost_full high: ignored, set trig_dropped.
- **WF_HDR** (one cycle)
  - select_waveform_hdr = 1; ptr increments.
  - If the latched burst count is 0: increment current_waveform_num, return to ARMED.
  - Otherwise load the burst down-counter and go to WF_DATA.
- **WF_DATA**
  - Each cycle with adc_burst_valid: select_dat = 1 and checksum_update = 1, ptr increments, counter decrements.
  - After the last burst: increment current_waveform_num, go to ARMED.
  - Data is never stalled.
- **FILL_HDR**
  - Wait while fifo_almost_full is high.
  - Then, for one cycle: select_fill_hdr = 1, num_fill_bursts = ptr + 1, go to CHECKSUM.
  - The fill header count covers the fill header, every waveform and the checksum.
- **CHECKSUM**
  - Wait while fifo_almost_full is high.
  - Then, for one cycle: select_checksum = 1, go to DONE.
- **DONE**: pulse fill_done, go to IDLE.

Boundary rules:
- Triggers arriving in WF_HDR or WF_DATA are ignored and set trig_dropped.
- fill_stop arriving in WF_HDR or WF_DATA sets the pending stop; the current waveform always completes.
- fill_stop and trigger in the same ARMED cycle: the stop wins and the trigger is ignored without setting trig_dropped.
- fill_stop outside an active fill (IDLE, FILL_HDR, CHECKSUM, DONE) is ignored.
- ptr, current_waveform_num and fill_num wrap modulo 2^width.
- wr_en asserted while fifo_full is high sets overflow; the write is still issued.

## Timing
- Selects are combinational from state and inputs.
- The mux registers its output, so wr_en is the OR of the selects delayed by one cycle. wr_adr is that word's address delayed by one cycle:
  - fill header: 0;
  - checksum: num_fill_bursts - 1;
  - all others: ptr.
- Header-field outputs are registered. They are stable in the cycle their select is high and hold until the next update.
- Trigger-to-header latency: the header select is high one cycle after the trigger cycle.
- The checksum select is high no earlier than one cycle after the fill header select. This ensures the fill header has been folded into the checksum.
- Reset:
  - state returns to IDLE;
  - all outputs go to 0, including fill_num and sticky flags;
  - a fill in progress is abandoned and no fill_done is issued.

## Configuration
- ASYNC_WF_LIMIT_EN defined: once current_waveform_num reaches MAX_WAVEFORMS, further ARMED triggers are ignored and set trig_dropped. fill_stop still ends the fill normally.
- ASYNC_WF_LIMIT_EN not defined: no per-fill cap on triggers. The waveform count is limited only by the 23-bit wrap.

## Test plan
- async_num_bursts = 3, fill_start, one trigger, 3 valid bursts, fill_stop:
  - writes in order: waveform header at adr 1, data at 2..4, fill header at 0 with num_fill_bursts = 6, checksum at 5;
  - current_waveform_num = 1; fill_done pulses once.
- Trigger during WF_DATA, then fill_stop during WF_DATA -> trig_dropped = 1, the waveform completes, then fill header and checksum follow.
- async_num_bursts = 0 with 2 triggers -> two header-only waveforms at adr 1 and 2, num_fill_bursts = 4.
- fifo_almost_full held high for 5 cycles in FILL_HDR -> select_fill_hdr is delayed exactly 5 cycles; wr_en with fifo_full high sets overflow.
- rst asserted mid WF_DATA -> next cycle all outputs are 0, no fill_done; a new fill_start yields fill_num = 1.
- With ASYNC_WF_LIMIT_EN and MAX_WAVEFORMS = 2, 3 triggers -> 2 waveforms, trig_dropped = 1.
